// File: rtl/dac_spi_receiver_if.sv
// SPI pins and decoded-frame outputs shared between the DAC transmitter and the receiver model.
// The master side drives the SPI lines; the slave side drives the decoded results.
interface dac_spi_receiver_if #(
  parameter int DATA_BITS = 10,
  parameter int ERR_W     = 8
);
  logic                 dac_sck;
  logic                 dac_sdi;
  logic                 dac_cs;
  logic [DATA_BITS-1:0] sample_out;
  logic                 sample_valid;
  logic                 cfg_ab;
  logic                 cfg_buf;
  logic                 cfg_gain_n;
  logic                 active;
  logic                 frame_err;
  logic [ERR_W-1:0]     err_count;
  logic                 busy;

  modport master (
    output dac_sck, dac_sdi, dac_cs,
    input  sample_out, sample_valid, cfg_ab, cfg_buf, cfg_gain_n,
           active, frame_err, err_count, busy
  );

  modport slave (
    input  dac_sck, dac_sdi, dac_cs,
    output sample_out, sample_valid, cfg_ab, cfg_buf, cfg_gain_n,
           active, frame_err, err_count, busy
  );
endinterface

// File: rtl/dac_spi_receiver.sv
// SPI responder model of a 10-bit MCP4911-style DAC: oversamples sck/sdi/cs, deserializes 16-bit frames.
// cs rise at pin to sample_valid/frame_err is SYNC_STAGES+2 clk; no backpressure, results are pulses.
module dac_spi_receiver #(
  parameter int FRAME_BITS  = 16,
  parameter int DATA_BITS   = 10,
  parameter int SYNC_STAGES = 2,
  parameter int ERR_W       = 8
) (
  input logic               clk,
  input logic               rst,
  dac_spi_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);
  localparam logic [FL_W-1:0]  FL_DONE  = FL_W'(SYNC_STAGES);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sck_prev_q, cs_prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], bus.dac_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], bus.dac_sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], bus.dac_cs};
      sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
      cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sck_s, sdi_s, cs_s;
  logic sck_rise, cs_rise, cs_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  state_t                  state_q;
  logic [FRAME_BITS-1:0]   shift_q;
  logic [FRAME_BITS-1:2]   frame_q;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [FL_W-1:0]         flush_q;
  logic                    accept_q, reject_q;
  logic [DATA_BITS-1:0]    sample_q;
  logic                    sample_valid_q;
  logic                    cfg_ab_q, cfg_buf_q, cfg_gain_n_q, active_q;
  logic                    frame_err_q;
  logic [ERR_W-1:0]        err_count_q, err_count_d;
  logic                    busy_q;

  always_comb begin
    bit_cnt_d   = (bit_cnt_q == CNT_MAX) ? bit_cnt_q : bit_cnt_q + 1'b1;
    err_count_d = (&err_count_q) ? err_count_q : err_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= WAIT_IDLE;
      shift_q        <= '0;
      frame_q        <= '0;
      bit_cnt_q      <= '0;
      flush_q        <= '0;
      accept_q       <= 1'b0;
      reject_q       <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      cfg_ab_q       <= 1'b0;
      cfg_buf_q      <= 1'b0;
      cfg_gain_n_q   <= 1'b0;
      active_q       <= 1'b0;
      frame_err_q    <= 1'b0;
      err_count_q    <= '0;
      busy_q         <= 1'b0;
    end else begin
      accept_q       <= 1'b0;
      reject_q       <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;

      // Results publish one cycle after the cs rise is seen, from the captured frame copy.
      if (accept_q) begin
        cfg_ab_q       <= frame_q[FRAME_BITS-1];
        cfg_buf_q      <= frame_q[FRAME_BITS-2];
        cfg_gain_n_q   <= frame_q[FRAME_BITS-3];
        active_q       <= frame_q[FRAME_BITS-4];
        sample_q       <= frame_q[FRAME_BITS-4] ? frame_q[DATA_BITS+1:2] : '0;
        sample_valid_q <= 1'b1;
      end
      if (reject_q) begin
        frame_err_q <= 1'b1;
        err_count_q <= err_count_d;
      end

      case (state_q)
        WAIT_IDLE: begin
          // The sync chain holds reset preload values until it has refilled from the pins.
          if (flush_q != FL_DONE) begin
            flush_q <= flush_q + 1'b1;
          end else if (cs_s) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (cs_fall) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= SHIFT;
            busy_q    <= 1'b1;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (bit_cnt_q == CNT_FULL) begin
              accept_q <= 1'b1;
              frame_q  <= shift_q[FRAME_BITS-1:2];
            end else begin
              reject_q <= 1'b1;
            end
          end else if (sck_rise && !cs_s) begin
            shift_q   <= {shift_q[FRAME_BITS-2:0], sdi_s};
            bit_cnt_q <= bit_cnt_d;
          end
        end
        default: begin
          state_q <= WAIT_IDLE;
          busy_q  <= 1'b0;
          flush_q <= '0;
        end
      endcase
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.cfg_ab       = cfg_ab_q;
  assign bus.cfg_buf      = cfg_buf_q;
  assign bus.cfg_gain_n   = cfg_gain_n_q;
  assign bus.active       = active_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.err_count    = err_count_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Bench for dac_spi_receiver: table of frames plus hand-built reset/saturation sequences,
// with a scoreboard queue checked whenever the DUT pulses sample_valid or frame_err.
module tb_dac_spi_receiver;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dac_spi_receiver_if bus ();

  dac_spi_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       is_err;
    logic [9:0] sample;
    logic       ab;
    logic       bf;
    logic       gain_n;
    logic       act;
    logic [7:0] errs;
  } exp_t;

  typedef struct {
    logic [16:0] frame;
    int          nbits;
    logic        is_err;
    logic [9:0]  sample;
    logic        ab;
    logic        bf;
    logic        gain_n;
    logic        act;
  } vec_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  vec_t       vecs[6];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] err_exp = 8'd0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [9:0] sample, input logic ab,
                          input logic bf, input logic gain_n, input logic act);
    exp_t e;
    if (is_err && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
    e.is_err = is_err;
    e.sample = sample;
    e.ab     = ab;
    e.bf     = bf;
    e.gain_n = gain_n;
    e.act    = act;
    e.errs   = err_exp;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && (bus.sample_valid === 1'b1 || bus.frame_err === 1'b1)) begin
      check("valid_err_exclusive", 32'(bus.sample_valid & bus.frame_err), 32'd0);
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse at %0t",
                 bus.sample_valid, bus.frame_err, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_kind_err", 32'(bus.frame_err), 32'(mon_e.is_err));
        check("sample_out", 32'(bus.sample_out), 32'(mon_e.sample));
        check("cfg_ab", 32'(bus.cfg_ab), 32'(mon_e.ab));
        check("cfg_buf", 32'(bus.cfg_buf), 32'(mon_e.bf));
        check("cfg_gain_n", 32'(bus.cfg_gain_n), 32'(mon_e.gain_n));
        check("active", 32'(bus.active), 32'(mon_e.act));
        check("err_count", 32'(bus.err_count), 32'(mon_e.errs));
      end
    end
  end

  // Clocks nbits of frame MSB first; sck half period of 4 clk keeps well above sync resolution.
  task automatic shift_bits(input logic [16:0] frame, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.dac_sdi = frame[i];
      repeat (4) @(negedge clk);
      bus.dac_sck = 1'b1;
      repeat (4) @(negedge clk);
      bus.dac_sck = 1'b0;
    end
  endtask

  task automatic apply_frame(input logic [16:0] frame, input int nbits, input logic expect_pulse);
    bus.dac_cs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(frame, nbits);
    repeat (4) @(negedge clk);
    check("busy_in_frame", 32'(bus.busy), 32'(expect_pulse));
    bus.dac_cs = 1'b1;
    repeat (3) @(negedge clk);
    check("no_pulse_before_4clk", 32'(bus.sample_valid | bus.frame_err), 32'd0);
    @(negedge clk);
    check("pulse_at_4clk", 32'(bus.sample_valid | bus.frame_err), 32'(expect_pulse));
    repeat (6) @(negedge clk);
    check("busy_after_frame", 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    err_exp = 8'd0;
  endtask

  initial begin
    vecs[0] = '{17'h03FFC, 16, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{17'h0C554, 16, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{17'h01554, 16, 1'b0, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{17'h07FFF, 15, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{17'h1FFFF, 17, 1'b1, 10'h155, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{17'h0B3F1, 16, 1'b0, 10'h0FC, 1'b1, 1'b0, 1'b1, 1'b1};

    bus.dac_sck = 1'b0;
    bus.dac_sdi = 1'b0;
    bus.dac_cs  = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample_out", 32'(bus.sample_out), 32'd0);
    check("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_err_count", 32'(bus.err_count), 32'd0);
    check("rst_active", 32'(bus.active), 32'd0);
    check("rst_cfg", 32'({bus.cfg_ab, bus.cfg_buf, bus.cfg_gain_n}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      push_exp(vecs[v].is_err, vecs[v].sample, vecs[v].ab, vecs[v].bf,
               vecs[v].gain_n, vecs[v].act);
      apply_frame(vecs[v].frame, vecs[v].nbits, 1'b1);
    end
    check("err_count_after_table", 32'(bus.err_count), 32'd2);

    // cs held low across reset release: the in-flight frame must be ignored entirely.
    bus.dac_cs = 1'b0;
    do_reset();
    @(negedge clk);
    check("rst_clears_sample", 32'(bus.sample_out), 32'd0);
    check("rst_clears_errs", 32'(bus.err_count), 32'd0);
    repeat (2) @(negedge clk);
    apply_frame(17'h000A5, 8, 1'b0);
    push_exp(1'b0, 10'h080, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_frame(17'h03200, 16, 1'b1);

    // Reset mid-frame after 9 bits, then a complete frame.
    bus.dac_cs = 1'b0;
    repeat (4) @(negedge clk);
    shift_bits(17'h001FF, 9);
    repeat (2) @(negedge clk);
    do_reset();
    @(negedge clk);
    check("midframe_rst_sample", 32'(bus.sample_out), 32'd0);
    check("midframe_rst_active", 32'(bus.active), 32'd0);
    repeat (4) @(negedge clk);
    bus.dac_cs = 1'b1;
    repeat (10) @(negedge clk);
    check("midframe_no_pulse_busy", 32'(bus.busy), 32'd0);
    push_exp(1'b0, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b1);
    apply_frame(17'h01AA8, 16, 1'b1);

    // Error counter saturation.
    for (int n = 0; n < 300; n++) begin
      push_exp(1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0, 1'b1);
      apply_frame(17'h00001, 1, 1'b1);
    end
    check("err_count_saturated", 32'(bus.err_count), 32'd255);
    push_exp(1'b0, 10'h3FF, 1'b0, 1'b0, 1'b1, 1'b1);
    apply_frame(17'h03FFC, 16, 1'b1);
    check("err_count_held", 32'(bus.err_count), 32'd255);

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_spi_receiver.md
Name: dac_spi_receiver

Overview:
- SPI responder model of the external 10-bit audio DAC; the receiving end of the dac_sdi/dac_cs/dac_sck link driven by the sound generator's DAC transmitter.
- Oversamples the three SPI lines in the system clock domain, deserializes 16-bit MCP4911-style frames, and publishes the decoded 10-bit sample and config bits.
- Used in simulation as the DAC stand-in and on FPGA as an on-chip loopback checker driving LEDs/debug.

Parameters:
- FRAME_BITS, 16, SPI bits per frame, MSB first.
- DATA_BITS, 10, sample width, located at frame bits [11:2].
- SYNC_STAGES, 2, synchronizer flops per SPI input, minimum 2.
- ERR_W, 8, width of the saturating frame-error counter.

Ports:
- clk  in  1  system clock, 12 MHz nominal.
- rst  in  1  synchronous, active-low reset.
- dac_sck  in  1  SPI clock, idle low; data is sampled on the rising edge.
- dac_sdi  in  1  SPI data (MOSI).
- dac_cs  in  1  chip select, active low.
- sample_out  out  DATA_BITS  last accepted sample; 0 while shutdown is active.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- cfg_ab  out  1  frame bit 15, latched on acceptance.
- cfg_buf  out  1  frame bit 14, latched on acceptance.
- cfg_gain_n  out  1  frame bit 13, latched on acceptance.
- active  out  1  latched frame bit 12 (SHDN_n); 0 means output shut down.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_count  out  ERR_W  saturating count of rejected frames.
- busy  out  1  high while a frame is in progress (state SHIFT).

Behaviour:
- Reset (rst=0 at a clk edge) clears all outputs to 0, clears the shift register and bit counter, preloads the sync chains to sck=0, sdi=0, cs=1, and enters WAIT_IDLE.
- Synchronization: each input passes through SYNC_STAGES flops; edges are detected on the last stage against a one-cycle delayed copy.
- Input latency is SYNC_STAGES+1 clk cycles from pin to edge detect.
- Sclk high and low phases must each be at least SYNC_STAGES+1 clk cycles; faster sclk is outside spec.
- State WAIT_IDLE: ignore everything until synced cs=1, then go to IDLE. This stops a frame already in progress at reset release from being accepted.
- State IDLE: on synced cs falling edge, clear the shift register and bit_cnt, then go to SHIFT.
- State SHIFT: on each synced sck rising edge with cs=0, shift in the synced sdi (LSB side, MSB-first stream) and increment bit_cnt (saturates at FRAME_BITS+1).
- State SHIFT, cs rising edge with bit_cnt==FRAME_BITS: accept the frame.
  - Next cycle, latch cfg_ab/cfg_buf/cfg_gain_n/active from bits [15:12].
  - Set sample_out = bits[11:2] if bit 12 is 1, else 0.
  - Pulse sample_valid for 1 cycle, then go to IDLE.
- State SHIFT, cs rising edge with bit_cnt != FRAME_BITS (short or long frame): leave all latched outputs unchanged.
  - Pulse frame_err for 1 cycle, increment err_count (hold at all-ones), then go to IDLE.
- Frame bits [1:0] are don't-care and are not checked.
- Simultaneous cs rising edge and sck rising edge in the same synced cycle: cs wins, the sck edge is not shifted.
- Sck edges while cs=1 are ignored in every state.
- A cs falling edge while in SHIFT cannot occur without an intervening rise; if the synchronizer skips a pulse narrower than sync resolution, no action is taken.
- Total latency, cs rising at pin to sample_valid: SYNC_STAGES+2 clk cycles.
- sample_valid and frame_err are never high in the same cycle.
- busy=1 exactly while in SHIFT.

Test Plan:
- Reset, then a 16-bit frame 0x3_FF_C (cfg bits 0011, data 0x3FF, tail 00) -> sample_valid pulses once after 4 clks; sample_out=10'h3FF, active=1, cfg_gain_n=1, cfg_buf=0, err_count=0.
- Frame with bit 12=0 and data 0x155 -> sample_out=0, active=0, sample_valid pulses; a following frame with SHDN_n=1 and data 0x155 -> sample_out=10'h155.
- 15-bit frame, then a 17-bit frame -> two frame_err pulses, err_count=2, sample_out unchanged from the prior value, no sample_valid.
- Hold cs low across reset release, clock 8 bits, raise cs -> no sample_valid, no frame_err; the next full frame 0x3_20_0 -> sample_out=10'h080.
- Assert reset mid-frame after 9 bits, release, send a full frame with data 0x2AA -> only the second frame is reported, sample_out=10'h2AA.
- 300 short frames -> err_count saturates at 255; then a valid frame -> sample_valid pulses and err_count stays 255.
